mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TBIT, default 64: operand and product width in bits.
REQ-002 Parameter LATENCY, default 8: cycles from mult_start sampled high to the matching mult_done high.
REQ-003 Ports: clock, in, 1, the only clock; all state updates on its rising edge.
REQ-004 Ports: reset, in, 1, asynchronous, active-low.
REQ-005 Ports: req0/req1, in, 1, multiply request from requester 0/1.
REQ-006 Ports: mplier0/mcand0/mplier1/mcand1, in, TBIT, operands from each requester.
REQ-007 Ports: kill0/kill1, in, 1, squash all in-flight and requesting ops of requester 0/1.
REQ-008 Ports: gnt0/gnt1, out, 1, combinational grant; the request is accepted in this cycle.
REQ-009 Ports: mult_start, out, 1, registered start pulse to the multiplier pipeline.
REQ-010 Ports: mult_mplier/mult_mcand, out, TBIT, registered operands to the pipeline.
REQ-011 Ports: mult_done, in, 1, pipeline completion strobe.
REQ-012 Ports: mult_product, in, TBIT, pipeline result, valid with mult_done.
REQ-013 Ports: result, out, TBIT, registered product returned to requesters.
REQ-014 Ports: result_valid0/result_valid1, out, 1, registered, one-cycle result strobe per requester.
REQ-015 Ports: busy, out, 1, high while any live op is in flight.
REQ-016 Ports: err, out, 1, sticky protocol-error flag.

Function
REQ-017 Grant: at most one gnt per cycle; gnt_k requires req_k high and kill_k low.
REQ-018 Arbitration: both requesters eligible -> grant the requester other than the last one granted (round-robin pointer); after reset the pointer favours requester 0.
REQ-019 Grant cycle T: operands of the granted requester are registered into mult_mplier/mult_mcand, and mult_start is high in cycle T+1 only.
REQ-020 No grant in T: mult_start is low in T+1 and mult_mplier/mult_mcand hold their values.
REQ-021 Tag pipe: a LATENCY-deep shift register records {live, id} per start; each entry is aligned so that it exits exactly when the matching mult_done arrives.
REQ-022 On mult_done with a live tag of id k: result <= mult_product and result_valid_k pulses one cycle later; end-to-end latency is grant T -> result_valid at T+LATENCY+2.
REQ-023 kill_k clears live on every tag-pipe entry of id k in that cycle, including the op started that cycle; a squashed op produces no result_valid, but result may still update.
REQ-024 Simultaneous kill_k and req_k: kill wins; no grant to k and the pointer is unchanged.
REQ-025 mult_done while the exiting tag slot was never started: err <= 1, sticky until reset. A started slot exiting without mult_done also sets err.
REQ-026 busy = OR of live bits in the tag pipe OR mult_start.
REQ-027 Back-to-back grants every cycle are supported; throughput is one op per cycle.

Reset
REQ-028 While reset is low: mult_start, result_valid0/1, err and all tag live bits = 0; mult_mplier, mult_mcand and result = 0; pointer favours requester 0.
REQ-029 Reset is asserted asynchronously and mid-operation discards all in-flight ops; mult_done arriving after release for pre-reset ops sets err.
REQ-030 gnt0/gnt1 are 0 while reset is low.

Configuration
REQ-031 MULT_ARBITER_RR_EN defined: round-robin arbitration per REQ-018.
REQ-032 MULT_ARBITER_RR_EN undefined: fixed priority, requester 0 over requester 1; the pointer logic is absent and all other behaviour is unchanged.

Verification
REQ-033 Single op: req0 with mplier0=3, mcand0=5 at T -> gnt0 at T, mult_start at T+1, result=15 with result_valid0 at T+10 (LATENCY=8).
REQ-034 Contention (RR_EN on): req0 and req1 held high for 4 cycles -> grants 0,1,0,1; results return in the same order, each 10 cycles after its grant.
REQ-035 Kill: grant req1 at T, kill1 at T+4 -> no result_valid1 at T+10, busy falls after the pipe drains, err stays 0.
REQ-036 Kill-vs-request: req0 and kill0 in the same cycle with req1 low -> no gnt0, mult_start low next cycle.
REQ-037 Protocol error: inject mult_done with the pipe empty -> err=1 next cycle, still 1 after 20 idle cycles.
REQ-038 Async reset: reset driven low mid-stream between clock edges -> all outputs 0 immediately, no result_valid after release.

Source files
------------

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester arbiter in front of a fixed-latency multiplier pipeline
// Optional round-robin arbitration under `MULT_ARBITER_RR_EN (fixed priority 0 > 1 otherwise).
module mult_arbiter #(
  parameter int TBIT    = 64,
  parameter int LATENCY = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic [TBIT-1:0] mplier0,
  input  logic [TBIT-1:0] mcand0,
  input  logic [TBIT-1:0] mplier1,
  input  logic [TBIT-1:0] mcand1,
  input  logic            kill0,
  input  logic            kill1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            mult_start,
  output logic [TBIT-1:0] mult_mplier,
  output logic [TBIT-1:0] mult_mcand,
  input  logic            mult_done,
  input  logic [TBIT-1:0] mult_product,
  output logic [TBIT-1:0] result,
  output logic            result_valid0,
  output logic            result_valid1,
  output logic            busy,
  output logic            err
);

  localparam int EX = LATENCY - 1;

  logic            mult_start_q;
  logic            start_id_q;
  logic [TBIT-1:0] mult_mplier_q, mult_mcand_q, result_q;
  logic            result_valid0_q, result_valid1_q, err_q;

  // One tag per pipeline stage; slot EX lines up with mult_done.
  logic [LATENCY-1:0] pipe_started_q, pipe_live_q, pipe_id_q;
  logic [LATENCY-1:0] pipe_started_d, pipe_live_d, pipe_id_d;
  logic [LATENCY-1:0] live_k;
  logic [LATENCY:0]   started_ext, live_ext, id_ext;
  logic               start_live_k;

  logic elig0, elig1, gnt_any;

  assign elig0 = reset & req0 & ~kill0;
  assign elig1 = reset & req1 & ~kill1;

`ifdef MULT_ARBITER_RR_EN
  logic ptr_q;
  assign gnt0 = elig0 & (~elig1 | ~ptr_q);
  assign gnt1 = elig1 & (~elig0 | ptr_q);
`else
  assign gnt0 = elig0;
  assign gnt1 = elig1 & ~elig0;
`endif

  assign gnt_any = gnt0 | gnt1;

  always_comb begin
    live_k       = '0;
    start_live_k = mult_start_q & ~(start_id_q ? kill1 : kill0);
    for (int i = 0; i < LATENCY; i++) begin
      live_k[i] = pipe_live_q[i] & ~(pipe_id_q[i] ? kill1 : kill0);
    end
    started_ext    = {pipe_started_q, mult_start_q};
    live_ext       = {live_k, start_live_k};
    id_ext         = {pipe_id_q, start_id_q};
    pipe_started_d = started_ext[LATENCY-1:0];
    pipe_live_d    = live_ext[LATENCY-1:0];
    pipe_id_d      = id_ext[LATENCY-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mult_start_q    <= 1'b0;
      start_id_q      <= 1'b0;
      mult_mplier_q   <= '0;
      mult_mcand_q    <= '0;
      result_q        <= '0;
      result_valid0_q <= 1'b0;
      result_valid1_q <= 1'b0;
      err_q           <= 1'b0;
      pipe_started_q  <= '0;
      pipe_live_q     <= '0;
      pipe_id_q       <= '0;
`ifdef MULT_ARBITER_RR_EN
      ptr_q           <= 1'b0;
`endif
    end else begin
      mult_start_q <= gnt_any;
      if (gnt_any) begin
        start_id_q    <= gnt1;
        mult_mplier_q <= gnt1 ? mplier1 : mplier0;
        mult_mcand_q  <= gnt1 ? mcand1  : mcand0;
`ifdef MULT_ARBITER_RR_EN
        ptr_q         <= gnt0;
`endif
      end
      pipe_started_q  <= pipe_started_d;
      pipe_live_q     <= pipe_live_d;
      pipe_id_q       <= pipe_id_d;
      result_valid0_q <= mult_done & pipe_started_q[EX] & live_k[EX] & ~pipe_id_q[EX];
      result_valid1_q <= mult_done & pipe_started_q[EX] & live_k[EX] &  pipe_id_q[EX];
      if (mult_done) begin
        result_q <= mult_product;
      end
      // Completion must coincide exactly with a started slot leaving the pipe.
      if (mult_done != pipe_started_q[EX]) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mult_start    = mult_start_q;
  assign mult_mplier   = mult_mplier_q;
  assign mult_mcand    = mult_mcand_q;
  assign result        = result_q;
  assign result_valid0 = result_valid0_q;
  assign result_valid1 = result_valid1_q;
  assign err           = err_q;
  assign busy          = (|pipe_live_q) | mult_start_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter
// Includes a fixed-latency multiplier stub driving mult_done/mult_product.
module tb_mult_arbiter;
  localparam int TBIT = 64;
  localparam int L    = 8;

  logic            clock, reset;
  logic            req0, req1, kill0, kill1;
  logic [TBIT-1:0] mplier0, mcand0, mplier1, mcand1;
  logic            gnt0, gnt1, mult_start, mult_done;
  logic [TBIT-1:0] mult_mplier, mult_mcand, mult_product, result;
  logic            result_valid0, result_valid1, busy, err;
  logic            inj_done;

  int tests_run = 0;
  int failed    = 0;

  mult_arbiter #(.TBIT(TBIT), .LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .mplier0(mplier0), .mcand0(mcand0), .mplier1(mplier1), .mcand1(mcand1),
    .kill0(kill0), .kill1(kill1),
    .gnt0(gnt0), .gnt1(gnt1),
    .mult_start(mult_start), .mult_mplier(mult_mplier), .mult_mcand(mult_mcand),
    .mult_done(mult_done), .mult_product(mult_product),
    .result(result), .result_valid0(result_valid0), .result_valid1(result_valid1),
    .busy(busy), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Multiplier stub: done is high in the L-th cycle after mult_start is sampled.
  logic [L-1:0]    sh_v;
  logic [TBIT-1:0] sh_p [L];
  initial begin
    sh_v = '0;
    for (int i = 0; i < L; i++) sh_p[i] = '0;
  end
  always @(posedge clock) begin
    sh_v <= {sh_v[L-2:0], mult_start};
    sh_p[0] <= mult_mplier * mult_mcand;
    for (int i = 1; i < L; i++) sh_p[i] <= sh_p[i-1];
  end
  assign mult_done    = sh_v[L-1] | inj_done;
  assign mult_product = sh_p[L-1];

`ifdef MULT_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; kill0 = 0; kill1 = 0; inj_done = 0;
    mplier0 = '0; mcand0 = '0; mplier1 = '0; mcand1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    repeat (12) step();
    reset = 0;
    step();
    step();
    reset = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    req0 = 1;
    #2 reset = 0;
    #1;
    tests_run++;
    if ({gnt0, gnt1, mult_start, result_valid0, result_valid1, err, busy} !== 7'b0) begin
      failed++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {gnt0, gnt1, mult_start, result_valid0, result_valid1, err, busy});
    end
    tests_run++;
    if ({mult_mplier, mult_mcand, result} !== '0) begin
      failed++;
      $display("FAIL reset_data: mplier=%0h mcand=%0h result=%0h expected 0", mult_mplier, mult_mcand, result);
    end
    req0 = 0;
    step();
    reset = 1;
    step();
  endtask

  task automatic test_single_op();
    do_reset();
    mplier0 = 3; mcand0 = 5; req0 = 1;
    #1;
    tests_run++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failed++;
      $display("FAIL single_gnt: got gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
    end
    step();
    req0 = 0;
    tests_run++;
    if (mult_start !== 1'b1 || mult_mplier !== 64'd3 || mult_mcand !== 64'd5 || busy !== 1'b1) begin
      failed++;
      $display("FAIL single_start: got start=%b mplier=%0d mcand=%0d busy=%b expected 1 3 5 1",
               mult_start, mult_mplier, mult_mcand, busy);
    end
    for (int c = 2; c <= 11; c++) begin
      step();
      tests_run++;
      if (result_valid0 !== (c == 10) || result_valid1 !== 1'b0 || (c == 2 && mult_start !== 1'b0)) begin
        failed++;
        $display("FAIL single_valid c=%0d: got rv0=%b rv1=%b start=%b expected rv0=%b", c,
                 result_valid0, result_valid1, mult_start, (c == 10));
      end
      if (c == 10) begin
        tests_run++;
        if (result !== 64'd15) begin
          failed++;
          $display("FAIL single_result: got %0d expected 15", result);
        end
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    mplier0 = 7; mcand0 = 9; mplier1 = 11; mcand1 = 13;
    for (int c = 0; c <= 14; c++) begin
      bit g, gid, vexp;
      int k;
      req0 = (c < 4); req1 = (c < 4);
      #1;
      g = RR ? (c % 2 == 1) : 1'b0;
      if (c < 4) begin
        tests_run++;
        if (gnt0 !== !g || gnt1 !== g) begin
          failed++;
          $display("FAIL cont_gnt c=%0d: got gnt0=%b gnt1=%b expected %b %b", c, gnt0, gnt1, !g, g);
        end
      end
      tests_run++;
      if (mult_start !== (c >= 1 && c <= 4)) begin
        failed++;
        $display("FAIL cont_start c=%0d: got %b expected %b", c, mult_start, (c >= 1 && c <= 4));
      end
      k    = c - 10;
      vexp = (c >= 10 && c <= 13);
      gid  = RR ? (k % 2 == 1) : 1'b0;
      tests_run++;
      if (result_valid0 !== (vexp && !gid) || result_valid1 !== (vexp && gid)) begin
        failed++;
        $display("FAIL cont_valid c=%0d: got rv0=%b rv1=%b expected %b %b", c,
                 result_valid0, result_valid1, (vexp && !gid), (vexp && gid));
      end
      if (vexp) begin
        tests_run++;
        if (result !== (gid ? 64'd143 : 64'd63)) begin
          failed++;
          $display("FAIL cont_result c=%0d: got %0d expected %0d", c, result, gid ? 143 : 63);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      bit vexp;
      logic [TBIT-1:0] pexp;
      req0 = (c < 3);
      mplier0 = 2 * c + 1; mcand0 = 2 * c + 2;
      #1;
      if (c < 3) begin
        tests_run++;
        if (gnt0 !== 1'b1) begin
          failed++;
          $display("FAIL b2b_gnt c=%0d: got %b expected 1", c, gnt0);
        end
      end
      if (c >= 1 && c <= 3) begin
        tests_run++;
        if (mult_start !== 1'b1 || mult_mplier !== 64'(2 * c - 1)) begin
          failed++;
          $display("FAIL b2b_start c=%0d: got start=%b mplier=%0d expected 1 %0d", c, mult_start, mult_mplier, 2 * c - 1);
        end
      end
      vexp = (c >= 10 && c <= 12);
      pexp = 64'((2 * (c - 10) + 1) * (2 * (c - 10) + 2));
      tests_run++;
      if (result_valid0 !== vexp || (vexp && result !== pexp)) begin
        failed++;
        $display("FAIL b2b_valid c=%0d: got rv0=%b result=%0d expected %b %0d", c, result_valid0, result, vexp, pexp);
      end
      step();
    end
  endtask

  task automatic test_kill();
    do_reset();
    mplier1 = 2; mcand1 = 4;
    for (int c = 0; c <= 12; c++) begin
      req1  = (c == 0);
      kill1 = (c == 4);
      #1;
      if (c == 0) begin
        tests_run++;
        if (gnt1 !== 1'b1) begin
          failed++;
          $display("FAIL kill_gnt: got %b expected 1", gnt1);
        end
      end
      if (c == 3) begin
        tests_run++;
        if (busy !== 1'b1) begin
          failed++;
          $display("FAIL kill_busy_before: got %b expected 1", busy);
        end
      end
      tests_run++;
      if (result_valid1 !== 1'b0 || result_valid0 !== 1'b0) begin
        failed++;
        $display("FAIL kill_valid c=%0d: got rv0=%b rv1=%b expected 0 0", c, result_valid0, result_valid1);
      end
      if (c == 12) begin
        tests_run++;
        if (busy !== 1'b0 || err !== 1'b0) begin
          failed++;
          $display("FAIL kill_drain: got busy=%b err=%b expected 0 0", busy, err);
        end
      end
      step();
    end
    kill1 = 0;
  endtask

  task automatic test_kill_vs_req();
    do_reset();
    req0 = 1; kill0 = 1;
    #1;
    tests_run++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      failed++;
      $display("FAIL killreq_gnt: got gnt0=%b gnt1=%b expected 0 0", gnt0, gnt1);
    end
    step();
    req0 = 0; kill0 = 0;
    tests_run++;
    if (mult_start !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL killreq_start: got start=%b busy=%b expected 0 0", mult_start, busy);
    end
  endtask

  task automatic test_protocol_err();
    do_reset();
    tests_run++;
    if (err !== 1'b0) begin
      failed++;
      $display("FAIL perr_clean: got %b expected 0", err);
    end
    inj_done = 1;
    step();
    inj_done = 0;
    tests_run++;
    if (err !== 1'b1) begin
      failed++;
      $display("FAIL perr_set: got %b expected 1", err);
    end
    repeat (20) step();
    tests_run++;
    if (err !== 1'b1) begin
      failed++;
      $display("FAIL perr_sticky: got %b expected 1", err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mplier0 = 3; mcand0 = 5; req0 = 1;
    repeat (3) step();
    #2 reset = 0;
    #1;
    tests_run++;
    if ({gnt0, gnt1, mult_start, result_valid0, result_valid1, err, busy} !== 7'b0 ||
        {mult_mplier, mult_mcand, result} !== '0) begin
      failed++;
      $display("FAIL areset_zero: got ctrl=%b mplier=%0h result=%0h expected all 0",
               {gnt0, gnt1, mult_start, result_valid0, result_valid1, err, busy}, mult_mplier, result);
    end
    req0 = 0;
    step();
    step();
    reset = 1;
    for (int c = 0; c < 15; c++) begin
      step();
      tests_run++;
      if (result_valid0 !== 1'b0 || result_valid1 !== 1'b0) begin
        failed++;
        $display("FAIL areset_valid c=%0d: got rv0=%b rv1=%b expected 0 0", c, result_valid0, result_valid1);
      end
    end
    tests_run++;
    if (err !== 1'b1) begin
      failed++;
      $display("FAIL areset_stale_done: got err=%b expected 1", err);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_back_to_back();
    test_kill();
    test_kill_vs_req();
    test_protocol_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
